temp_sampler: RTL and testbench
===============================

# temp_sampler

Periodic temperature acquisition stage sitting directly downstream of `spi_handler_thermometer`. It issues `data_request` to the SPI handler on a fixed sample period and waits for `data_valid`. It extracts the 10-bit temperature code from the 16-bit thermometer word and feeds it to a moving-average filter. It presents a filtered, registered temperature with a one-cycle valid strobe to the thermostat control logic.

## Interface
- `SAMPLE_PERIOD`, 20000: cycles between request rising edges (1 s at 20 kHz); minimum 4.
- `TIMEOUT`, 2000: max cycles to wait for `i_data_valid` after request asserted; minimum 2.
- `AVG_LOG2`, 2: log2 of averaging window depth (4 entries); range 0–4.

Ports:
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_enable` in 1: permits new requests.
- `o_data_request` out 1: request to SPI handler.
- `i_data` in 16: thermometer word from SPI handler.
- `i_data_valid` in 1: SPI handler data valid.
- `o_temperature` out 10: filtered temperature code.
- `o_temp_valid` out 1: one-cycle strobe when `o_temperature` updates.
- `o_temp_ready` out 1: level; high once at least one sample has been filtered.
- `o_timeout` out 1: sticky; cleared by the next successful read.

## Operation
- FSM states and transitions:
  - IDLE → REQUEST when `i_enable`=1 and period counter = 0.
  - REQUEST → RELEASE on `i_data_valid`=1 (capture) or when the timeout counter expires.
  - RELEASE → IDLE when `i_data_valid`=0.
- `o_data_request` is high exactly while in REQUEST.
- Period counter:
  - Reset value 0, so the first request is issued as soon as enabled.
  - Reloads to `SAMPLE_PERIOD`-1 on IDLE→REQUEST.
  - Decrements every cycle while nonzero, in every state.
- Timeout counter: loads `TIMEOUT`-1 on entering REQUEST. Expiry at 0 with no valid drops the request, sets `o_timeout`, and discards the sample.
- Capture:
  - Code = `i_data[14:5]`.
  - If `i_data[15]`=1 (sign), the code is clamped to 0.
  - A successful capture clears `o_timeout`.
- Filter:
  - Circular buffer of 2^`AVG_LOG2` entries with a running sum of width 10+`AVG_LOG2`.
  - First sample after reset preloads every entry with the sample and sets sum = sample<<`AVG_LOG2`.
  - Each later sample: sum = sum − oldest + new; write pointer wraps modulo depth.
  - Output = sum>>`AVG_LOG2` (truncating).
- `i_enable` falling does not abort an active REQUEST. It only blocks the next IDLE→REQUEST.
- `i_data_valid` held high: no new request is issued until it falls (RELEASE guard).

## Timing
- All outputs reset to 0: `o_data_request`, `o_temperature`, `o_temp_valid`, `o_temp_ready`, `o_timeout`. Buffer and sum are cleared, and the first-sample flag is set.
- Capture edge N (REQUEST with `i_data_valid`=1): `i_data` is registered and `o_data_request`=0 after N.
- Edge N+1: buffer and sum are updated.
- Edge N+2: `o_temperature` is updated and `o_temp_valid` is high for exactly one cycle. On the first sample, `o_temp_ready` rises on the same edge.
- Timeout: request is high for exactly `TIMEOUT` cycles. `o_timeout` rises on the edge that drops the request.
- Request rising edges are spaced exactly `SAMPLE_PERIOD` cycles apart when each transaction completes in less than `SAMPLE_PERIOD` cycles. Otherwise the next request follows the cycle after RELEASE→IDLE.
- Reset asserted mid-operation forces all outputs to 0 immediately, without waiting for a clock edge. The next sample re-preloads the filter.

## Structure
- Shared package `thermostat_pkg` holds:
  - `TEMP_W`=10 and `RAW_W`=16.
  - Field constants `TEMP_MSB`=14, `TEMP_LSB`=5, `SIGN_BIT`=15.
  - FSM state encoding.
- One sub-module, `temp_avg_filter`: circular buffer, pointer, running sum and preload. It takes a sample with a strobe and returns the average with a strobe.

## Test plan
All scenarios use `SAMPLE_PERIOD`=100 and `TIMEOUT`=50.

- First sample: `i_data`=16'h0C80 → `o_temperature`=100 two cycles after the capture edge, `o_temp_valid` single pulse, `o_temp_ready`=1.
- Averaging: after the preload at 100, send 16'h0F00 (code 120) → outputs 105, 110, 115, 120 on four successive samples; holds at 120 thereafter.
- Negative word: `i_data`=16'h8C80 on a filter holding 100 → output 75.
- Timeout: never assert valid → request high 50 cycles then low, `o_timeout`=1, no `o_temp_valid`. Next good read (16'h0C80) clears `o_timeout`.
- Spacing and guards:
  - With valid answered 10 cycles after request, rising edges are 100 cycles apart.
  - `i_enable`=0 during REQUEST → that read completes and no further requests follow.
  - Valid held high → no request until it falls.
- Reset mid-REQUEST: `o_data_request` drops asynchronously and all outputs are 0. After release, the first sample (16'h0F00) outputs 120 directly, confirming the preload.

Source files
------------

// File: rtl/thermostat_pkg.sv
// Shared thermostat constants: word geometry, temperature field location, sampler FSM encoding.
// Pure definitions, no logic.
package thermostat_pkg;

  localparam int TEMP_W   = 10;
  localparam int RAW_W    = 16;
  localparam int TEMP_MSB = 14;
  localparam int TEMP_LSB = 5;
  localparam int SIGN_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_RELEASE = 2'd2
  } sampler_state_t;

  // A negative reading is below anything the thermostat regulates, so it saturates to zero.
  function automatic logic [TEMP_W-1:0] extract_code(input logic [RAW_W-1:0] raw);
    logic [TEMP_W-1:0] code;
    code = raw[TEMP_MSB:TEMP_LSB];
    if (raw[SIGN_BIT]) begin
      code = '0;
    end
    return code;
  endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// Sampler bus: SPI-handler request/data side plus filtered temperature side.
// master = sampler, slave = SPI handler / thermostat logic.
interface temp_sampler_if;
  import thermostat_pkg::*;

  logic              i_enable;
  logic              o_data_request;
  logic [RAW_W-1:0]  i_data;
  logic              i_data_valid;
  logic [TEMP_W-1:0] o_temperature;
  logic              o_temp_valid;
  logic              o_temp_ready;
  logic              o_timeout;

  modport master (
    input  i_enable, i_data, i_data_valid,
    output o_data_request, o_temperature, o_temp_valid, o_temp_ready, o_timeout
  );

  modport slave (
    output i_enable, i_data, i_data_valid,
    input  o_data_request, o_temperature, o_temp_valid, o_temp_ready, o_timeout
  );

endinterface

// File: rtl/temp_avg_filter.sv
// Moving-average filter over 2^AVG_LOG2 samples with first-sample preload.
// Latency: sample strobe -> sum update +1 cycle -> registered average strobe +2 cycles.
// No backpressure: every sample strobe is absorbed.
module temp_avg_filter
  import thermostat_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              sample_vld,
  input  logic [TEMP_W-1:0] sample_dat,
  output logic              avg_vld,
  output logic [TEMP_W-1:0] avg_dat,
  output logic              primed
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int SUM_W = TEMP_W + AVG_LOG2;

  logic [TEMP_W-1:0] ring [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [SUM_W-1:0]  sum;
  logic              first;
  logic              sum_upd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
      wr_ptr  <= '0;
      sum     <= '0;
      first   <= 1'b1;
      sum_upd <= 1'b0;
      avg_vld <= 1'b0;
      avg_dat <= '0;
      primed  <= 1'b0;
    end else begin
      sum_upd <= sample_vld;
      avg_vld <= sum_upd;
      if (sum_upd) begin
        avg_dat <= TEMP_W'(sum >> AVG_LOG2);
        primed  <= 1'b1;
      end
      if (sample_vld) begin
        if (first) begin
          // Fill the whole window so the first output equals the first sample.
          for (int i = 0; i < DEPTH; i++) begin
            ring[i] <= sample_dat;
          end
          sum   <= SUM_W'(sample_dat) << AVG_LOG2;
          first <= 1'b0;
        end else begin
          ring[wr_ptr] <= sample_dat;
          sum          <= sum - SUM_W'(ring[wr_ptr]) + SUM_W'(sample_dat);
        end
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// Periodic thermometer acquisition: request/valid exchange with the SPI handler, capture, averaging.
// Latency: capture edge N -> filtered temperature strobe on edge N+2.
// Backpressure: a held data_valid parks the FSM in RELEASE; no new request until it falls.
module temp_sampler
  import thermostat_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 20000,
  parameter int TIMEOUT       = 2000,
  parameter int AVG_LOG2      = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  temp_sampler_if.master bus
);

  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
  localparam int TCNT_W = $clog2(TIMEOUT);

  sampler_state_t    state, state_nxt;
  logic [PCNT_W-1:0] period_cnt;
  logic [TCNT_W-1:0] tmo_cnt;
  logic              start_req;
  logic              capture;
  logic              expire;
  logic              cap_vld;
  logic [TEMP_W-1:0] cap_dat;
  logic              timeout_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_req = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_enable && period_cnt == '0) begin
          state_nxt = ST_REQUEST;
          start_req = 1'b1;
        end
      end
      ST_REQUEST: begin
        if (bus.i_data_valid) begin
          state_nxt = ST_RELEASE;
          capture   = 1'b1;
        end else if (tmo_cnt == '0) begin
          state_nxt = ST_RELEASE;
          expire    = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!bus.i_data_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Period counter runs free of the FSM so request edges stay on the sample grid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      period_cnt <= '0;
      tmo_cnt    <= '0;
      cap_vld    <= 1'b0;
      cap_dat    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (start_req) begin
        period_cnt <= PCNT_W'(SAMPLE_PERIOD - 1);
      end else if (period_cnt != '0) begin
        period_cnt <= period_cnt - 1'b1;
      end

      if (start_req) begin
        tmo_cnt <= TCNT_W'(TIMEOUT - 1);
      end else if (state == ST_REQUEST && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end

      cap_vld <= capture;
      if (capture) begin
        cap_dat <= extract_code(bus.i_data);
      end

      if (expire) begin
        timeout_q <= 1'b1;
      end else if (capture) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign bus.o_data_request = (state == ST_REQUEST);
  assign bus.o_timeout      = timeout_q;

  temp_avg_filter #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_filter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .sample_vld (cap_vld),
    .sample_dat (cap_dat),
    .avg_vld    (bus.o_temp_valid),
    .avg_dat    (bus.o_temperature),
    .primed     (bus.o_temp_ready)
  );

endmodule

// File: tb/tb_temp_sampler.sv
// Bench for temp_sampler: table of reads with expected averages through a scoreboard,
// plus hand sequences for timeout, enable drop, held valid and asynchronous reset.
module tb_temp_sampler;

  localparam int SP = 100;
  localparam int TO = 50;
  localparam int AL = 2;

  logic r_sys_clk = 1'b0;
  logic rst_n     = 1'b0;
  always #5 r_sys_clk = ~r_sys_clk;

  temp_sampler_if bus();

  temp_sampler #(
    .SAMPLE_PERIOD (SP),
    .TIMEOUT       (TO),
    .AVG_LOG2      (AL)
  ) dut (
    .i_clk   (r_sys_clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];
  int cap_q[$];
  int rise_cnt  = 0;
  int last_rise = 0;
  int vld_cnt   = 0;
  logic prev_req = 1'b0;
  logic prev_vld = 1'b0;

  typedef struct {
    logic [15:0] dat;
    int          exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge r_sys_clk) cyc <= cyc + 1;

  always @(negedge r_sys_clk) begin
    if (rst_n) begin
      if (bus.o_data_request && !prev_req) begin
        rise_cnt  <= rise_cnt + 1;
        last_rise <= cyc;
      end
      if (bus.o_temp_valid) begin
        vld_cnt <= vld_cnt + 1;
        chk("temp_valid_single_pulse", int'(prev_vld), 0);
        chk("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("temperature", int'(bus.o_temperature), exp_q.pop_front());
        chk("capture_recorded", int'(cap_q.size() > 0), 1);
        if (cap_q.size() > 0) chk("capture_to_valid_latency", cyc - cap_q.pop_front(), 2);
        chk("temp_ready_with_valid", int'(bus.o_temp_ready), 1);
      end
    end
    prev_req <= bus.o_data_request;
    prev_vld <= bus.o_temp_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge r_sys_clk);
      #1;
    end
  endtask

  task automatic wait_rise(input int budget);
    int  c0;
    bit  seen;
    c0   = rise_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (rise_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("request_within_budget", int'(seen), 1);
  endtask

  // Drive valid while the request is up; capture happens on the next rising edge.
  task automatic answer(input logic [15:0] d, input int exp, input int dly, input int hold);
    tick(dly);
    chk("request_high_when_answered", int'(bus.o_data_request), 1);
    bus.i_data       = d;
    bus.i_data_valid = 1'b1;
    exp_q.push_back(exp);
    cap_q.push_back(cyc + 1);
    tick(1);
    chk("request_dropped_on_capture", int'(bus.o_data_request), 0);
    tick(hold);
    bus.i_data_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int prev_rise;
    int c0;
    int v0;
    int hi;
    int drop_cyc;

    vecs[0] = '{16'h0C80, 100};
    vecs[1] = '{16'h0F00, 105};
    vecs[2] = '{16'h0F00, 110};
    vecs[3] = '{16'h0F00, 115};
    vecs[4] = '{16'h0F00, 120};
    vecs[5] = '{16'h0F00, 120};
    vecs[6] = '{16'h8C80,  90};
    vecs[7] = '{16'h7FE0, 315};

    bus.i_enable     = 1'b0;
    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
    tick(3);
    chk("rst_request",  int'(bus.o_data_request), 0);
    chk("rst_temp",     int'(bus.o_temperature), 0);
    chk("rst_valid",    int'(bus.o_temp_valid), 0);
    chk("rst_ready",    int'(bus.o_temp_ready), 0);
    chk("rst_timeout",  int'(bus.o_timeout), 0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_while_disabled", rise_cnt, 0);

    bus.i_enable = 1'b1;
    prev_rise = 0;
    for (int i = 0; i < 8; i++) begin
      wait_rise(300);
      if (i > 0) chk("request_spacing", last_rise - prev_rise, SP);
      prev_rise = last_rise;
      answer(vecs[i].dat, vecs[i].exp, 10, 0);
      drain();
    end
    chk("no_timeout_after_table", int'(bus.o_timeout), 0);

    // Unanswered request: exactly TO cycles high, sticky flag, no output.
    wait_rise(300);
    v0 = vld_cnt;
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (!bus.o_data_request) break;
      hi++;
    end
    chk("timeout_request_width", hi, TO);
    chk("timeout_flag_set", int'(bus.o_timeout), 1);
    tick(10);
    chk("no_valid_on_timeout", vld_cnt - v0, 0);
    chk("timeout_sticky", int'(bus.o_timeout), 1);
    wait_rise(300);
    answer(16'h0C80, 310, 10, 0);
    drain();
    chk("timeout_cleared", int'(bus.o_timeout), 0);

    // Enable drop mid-request: the read finishes, nothing follows.
    wait_rise(300);
    bus.i_enable = 1'b0;
    answer(16'h0C80, 305, 10, 0);
    drain();
    c0 = rise_cnt;
    tick(300);
    chk("no_request_when_disabled", rise_cnt - c0, 0);

    // Valid held past the period: RELEASE guard holds off the next request.
    bus.i_enable = 1'b1;
    wait_rise(300);
    c0 = rise_cnt;
    answer(16'h0F00, 335, 10, 150);
    drop_cyc = cyc;
    drain();
    chk("no_request_while_valid_held", rise_cnt - c0, 0);
    wait_rise(300);
    chk("request_after_valid_falls", last_rise - drop_cyc, 2);
    answer(16'h0F00, 110, 10, 0);
    drain();

    // Asynchronous reset in the middle of a request.
    wait_rise(300);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("arst_request", int'(bus.o_data_request), 0);
    chk("arst_temp",    int'(bus.o_temperature), 0);
    chk("arst_valid",   int'(bus.o_temp_valid), 0);
    chk("arst_ready",   int'(bus.o_temp_ready), 0);
    chk("arst_timeout", int'(bus.o_timeout), 0);
    tick(2);
    rst_n = 1'b1;
    wait_rise(300);
    answer(16'h0F00, 120, 10, 0);
    drain();

    // Negative word against a filter preloaded at 100.
    do_reset();
    wait_rise(300);
    answer(16'h0C80, 100, 10, 0);
    drain();
    wait_rise(300);
    answer(16'h8C80, 75, 10, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
